// File: rtl/serial_subtractor_8bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_8bit
// Brief    : Bit-serial subtractor, diff = a - b - borrow_in, LSB first, with a
//            start/busy/done handshake. Optional macro SUB_SIGNED_OVF_EN adds
//            the ovf_signed output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_8bit #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                underflow
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic                ovf_signed
`endif
);

    localparam int            CW      = $clog2(NUM_BITS);
    localparam logic [CW-1:0] C_LAST  = CW'(NUM_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_BITS-1:0] sa_q, sa_d;
    logic [NUM_BITS-1:0] sb_q, sb_d;
    logic                br_q, br_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // Only NUM_BITS-1 result bits are kept; the final bit goes straight to diff.
    logic [NUM_BITS-2:0] res_q, res_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                underflow_q, underflow_d;

    logic accept;
    logic last;
    logic bit_w;
    logic br_next;

    assign accept  = start && (state_q != S_SHIFT);
    assign last    = (state_q == S_SHIFT) && (cnt_q == C_LAST);
    assign bit_w   = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == C_LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
    end

    always_comb begin
        sa_d        = sa_q;
        sb_d        = sb_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        diff_d      = diff_q;
        underflow_d = underflow_q;
        if (accept) begin
            sa_d  = a;
            sb_d  = b;
            br_d  = borrow_in;
            cnt_d = '0;
            res_d = '0;
        end else if (state_q == S_SHIFT) begin
            sa_d  = {1'b0, sa_q[NUM_BITS-1:1]};
            sb_d  = {1'b0, sb_q[NUM_BITS-1:1]};
            br_d  = br_next;
            res_d = {bit_w, res_q} >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                diff_d      = {bit_w, res_q};
                underflow_d = br_next;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q        <= '0;
            sb_q        <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            underflow_q <= underflow_d;
        end
    end

    assign diff      = diff_q;
    assign underflow = underflow_q;

`ifdef SUB_SIGNED_OVF_EN
    // Operand MSBs are kept because sa/sb have shifted them out by completion.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = a[NUM_BITS-1];
            b_msb_d = b[NUM_BITS-1];
        end else if (last) begin
            ovf_d = (a_msb_q != b_msb_q) && (bit_w != a_msb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf_signed = ovf_q;
`endif

endmodule
`default_nettype wire
